dmem_port_arbiter: RTL



---
 rtl/dmem_port_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 normally wins; port 1 is forced through after MAX_WAIT denied cycles.
module dmem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MEM_BITS = 16
) (
  input  logic        i_clk,
  input  logic        rst_n,

  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_func3,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_func3,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,

  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_w_data,
  output logic [2:0]  o_func3,
  input  logic [31:0] i_r_data
);

  localparam int unsigned     CNT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] hi;
    hi = addr >> MEM_BITS;
    return (hi == 32'd0);
  endfunction

  function automatic logic access_legal(input logic we, input logic [31:0] addr,
                                        input logic [2:0] func3);
    logic size_ok;
    if (we) begin
      case (func3)
        3'b000, 3'b001, 3'b010: size_ok = 1'b1;
        default:                size_ok = 1'b0;
      endcase
    end else begin
      case (func3)
        3'b011, 3'b110, 3'b111: size_ok = 1'b0;
        default:                size_ok = 1'b1;
      endcase
    end
    return size_ok && addr_in_range(addr);
  endfunction

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             p0_rvalid_q, p0_rvalid_d;
  logic [31:0]      p0_rdata_q,  p0_rdata_d;
  logic             p0_err_q,    p0_err_d;
  logic             p1_rvalid_q, p1_rvalid_d;
  logic [31:0]      p1_rdata_q,  p1_rdata_d;
  logic             p1_err_q,    p1_err_d;

  logic             grant0_s, grant1_s, any_grant_s, legal_s;
  logic             sel_we_s;
  logic [31:0]      sel_addr_s, sel_wdata_s;
  logic [2:0]       sel_func3_s;

  // Grant selection; gated by rst_n so nothing is accepted or driven while in reset.
  always_comb begin
    grant1_s    = rst_n & p1_valid & (~p0_valid | (starve_q == CNT_MAX));
    grant0_s    = rst_n & p0_valid & ~grant1_s;
    any_grant_s = grant0_s | grant1_s;
    if (grant1_s) begin
      sel_we_s    = p1_we;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
      sel_func3_s = p1_func3;
    end else begin
      sel_we_s    = p0_we;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
      sel_func3_s = p0_func3;
    end
    legal_s = any_grant_s & access_legal(sel_we_s, sel_addr_s, sel_func3_s);
  end

  // Memory drive: only a legal granted request reaches the memory.
  always_comb begin
    if (legal_s) begin
      o_wr_en  = sel_we_s;
      o_addr   = sel_addr_s;
      o_w_data = sel_wdata_s;
      o_func3  = sel_func3_s;
    end else begin
      o_wr_en  = 1'b0;
      o_addr   = 32'd0;
      o_w_data = 32'd0;
      o_func3  = 3'b000;
    end
    p0_ready = grant0_s;
    p1_ready = grant1_s;
  end

  // Starvation counter: counts consecutive cycles port 1 waits, saturating.
  always_comb begin
    if (!p1_valid || grant1_s) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_ONE;
    end else begin
      starve_d = starve_q;
    end
  end

  // Next response per port; load data is taken from the memory at the grant edge.
  always_comb begin
    p0_rvalid_d = grant0_s;
    p0_err_d    = grant0_s & ~legal_s;
    if (grant0_s && legal_s && !sel_we_s) begin
      p0_rdata_d = i_r_data;
    end else begin
      p0_rdata_d = 32'd0;
    end
    p1_rvalid_d = grant1_s;
    p1_err_d    = grant1_s & ~legal_s;
    if (grant1_s && legal_s && !sel_we_s) begin
      p1_rdata_d = i_r_data;
    end else begin
      p1_rdata_d = 32'd0;
    end
  end

  // State and response registers; reset discards any pending response.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p0_rdata_q  <= 32'd0;
      p0_err_q    <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p1_rdata_q  <= 32'd0;
      p1_err_q    <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      p0_rvalid_q <= p0_rvalid_d;
      p0_rdata_q  <= p0_rdata_d;
      p0_err_q    <= p0_err_d;
      p1_rvalid_q <= p1_rvalid_d;
      p1_rdata_q  <= p1_rdata_d;
      p1_err_q    <= p1_err_d;
    end
  end

  assign p0_rvalid = p0_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p0_err    = p0_err_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p1_rdata  = p1_rdata_q;
  assign p1_err    = p1_err_q;

endmodule
